// File: rtl/bomb_sequencer.sv
// Round controller for the bomb: picks the live puzzle modules on start, runs the
// countdown and strike count while armed, and holds the win/loss result until the next start.
module bomb_sequencer #(
  parameter int unsigned TICK_CYCLES   = 27_000_000,
  parameter int unsigned START_SECONDS = 300,
  parameter int unsigned MAX_STRIKES   = 3,
  parameter logic [3:0]  FIXED_MASK    = 4'b0000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] module_defused,
  input  logic [3:0] module_strike,
  output logic [3:0] enable,
  output logic       accum_enable,
  output logic [9:0] seconds_left,
  output logic [1:0] strikes,
  output logic       game_won,
  output logic       game_lost,
  output logic       busy
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [2:0] MAX_S3 = 3'(MAX_STRIKES);
  localparam logic [9:0] START_S = 10'(START_SECONDS);
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {StIdle, StSetup, StArmed, StWon, StLost} state_e;

  state_e        state;
  logic [15:0]   lfsr;
  logic [3:0]    mask;
  logic [PW-1:0] prescale;

  logic [15:0] lfsr_next;
  logic [3:0]  sel_mask;
  logic [3:0]  start_mask;
  logic [3:0]  hit;
  logic [2:0]  strike_sum;
  logic [1:0]  new_strikes;
  logic        tick;
  logic        win;
  logic        loss;

  always_comb begin
    lfsr_next   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    sel_mask    = (FIXED_MASK != 4'b0000) ? FIXED_MASK : lfsr[3:0];
    // A round always has at least two live modules.
    start_mask  = ($countones(sel_mask) < 2) ? (sel_mask | 4'b0011) : sel_mask;
    hit         = module_strike & enable;
    strike_sum  = {1'b0, strikes} + {2'b0, hit[0]} + {2'b0, hit[1]}
                + {2'b0, hit[2]} + {2'b0, hit[3]};
    new_strikes = (strike_sum >= MAX_S3) ? MAX_S3[1:0] : strike_sum[1:0];
    tick        = (prescale == TICK_LAST);
    win         = ((module_defused & enable) == enable);
    loss        = ({1'b0, new_strikes} == MAX_S3) || (tick && seconds_left == 10'd1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      lfsr         <= LFSR_SEED;
      mask         <= 4'b0000;
      prescale     <= '0;
      enable       <= 4'b0000;
      accum_enable <= 1'b0;
      seconds_left <= 10'd0;
      strikes      <= 2'd0;
      game_won     <= 1'b0;
      game_lost    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      lfsr <= lfsr_next;
      unique case (state)
        StIdle, StWon, StLost: begin
          if (start) begin
            state        <= StSetup;
            mask         <= start_mask;
            seconds_left <= START_S;
            strikes      <= 2'd0;
            game_won     <= 1'b0;
            game_lost    <= 1'b0;
            prescale     <= '0;
            busy         <= 1'b1;
          end
        end
        StSetup: begin
          state        <= StArmed;
          enable       <= mask;
          accum_enable <= 1'b1;
        end
        StArmed: begin
          strikes  <= new_strikes;
          prescale <= tick ? '0 : prescale + 1'b1;
          if (tick && seconds_left != 10'd0) seconds_left <= seconds_left - 10'd1;
          if (win || loss) begin
            state        <= win ? StWon : StLost;
            game_won     <= win;
            game_lost    <= !win;
            enable       <= 4'b0000;
            accum_enable <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
